// File: rtl/rv_wb_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
package rv_wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_BYPASS
  } src_e;

endpackage

// File: rtl/wb_ll_fifo.sv
// Synchronous FIFO of pending long-latency write-back entries.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_ll_fifo
  import rv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  wb_entry_t              din,
  output logic                   full,
  output logic                   empty,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and long-latency results onto the single register-file write port.
// Optional busy-register scoreboard enabled by defining SCOREBOARD_EN.
module wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int unsigned LL_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ll_valid,
  output logic                  ll_ready,
  input  logic [REG_ADDR_W-1:0] ll_rd,
  input  logic [XLEN-1:0]       ll_data,
  output logic                  stall_req,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic [NUM_REGS-1:0]   busy_mask
);

  localparam int unsigned LW = $clog2(LL_DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  src_e            sel;
  wb_entry_t       sel_entry;
  wb_entry_t       head;
  wb_entry_t       ll_entry;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            do_write;
  logic [LW-1:0]   level;
  logic [LW-1:0]   level_next;
  logic [SW-1:0]   starve_cnt;
  logic [SW-1:0]   starve_next;

  assign ll_entry.rd   = ll_rd;
  assign ll_entry.data = ll_data;

  wb_ll_fifo #(.DEPTH(LL_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ll_entry),
    .full  (full),
    .empty (empty),
    .head  (head),
    .level (level)
  );

  // Fixed priority: ALU, queued head, empty-queue bypass.
  always_comb begin
    sel       = SRC_NONE;
    sel_entry = '0;
    if (alu_valid) begin
      sel            = SRC_ALU;
      sel_entry.rd   = alu_rd;
      sel_entry.data = alu_data;
    end else if (!empty) begin
      sel       = SRC_FIFO;
      sel_entry = head;
    end else if (ll_valid) begin
      sel       = SRC_BYPASS;
      sel_entry = ll_entry;
    end
  end

  assign ll_ready   = !full;
  assign pop        = (sel == SRC_FIFO);
  assign push       = ll_valid && ll_ready && (sel != SRC_BYPASS);
  assign level_next = level + LW'(push) - LW'(pop);
  assign do_write   = (sel != SRC_NONE) && (sel_entry.rd != '0);

  // Counts consecutive losses of a waiting head to the ALU.
  always_comb begin
    starve_next = starve_cnt;
    if (empty || pop) begin
      starve_next = '0;
    end else if ((sel == SRC_ALU) && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_next = starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      starve_cnt <= starve_next;
      stall_req  <= (starve_next == SW'(STARVE_LIMIT)) || (level_next == LW'(LL_DEPTH));
      wb_we      <= do_write;
      if (do_write) begin
        wb_rd   <= sel_entry.rd;
        wb_data <= sel_entry.data;
      end
    end
  end

`ifdef SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // A new issue to the same register outranks the retirement of the old one.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if ((sel == SRC_FIFO) || (sel == SRC_BYPASS)) clr_mask[sel_entry.rd] = 1'b1;
    if (issue_valid && (issue_rd != '0))          set_mask[issue_rd]     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

  assign busy_mask = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_rd};
  assign busy_mask    = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, corner sequences, then
// randomized traffic against a queue-based reference model.
module tb_wb_arbiter;
  import rv_wb_pkg::*;

  localparam int unsigned LL_DEPTH     = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  typedef struct {
    logic        r;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ird;
    logic        ewe;
    logic [4:0]  erd;
    logic [31:0] ed;
    logic        estall;
    logic        erdy;
    logic [31:0] ebusy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        stall_req;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.LL_DEPTH(LL_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ll_valid    (ll_valid),
    .ll_ready    (ll_ready),
    .ll_rd       (ll_rd),
    .ll_data     (ll_data),
    .stall_req   (stall_req),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy_mask   (busy_mask)
  );

  // Upstream must never present an ALU result while a stall is requested.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(stall_req && alu_valid))
      else begin
        errors++;
        $error("FAIL contract alu_valid high while stall_req high");
      end
    end
  end

  function automatic vec_t v(input logic r, input logic av, input logic [4:0] ard,
                             input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                             input logic [31:0] ld, input logic ewe, input logic [4:0] erd,
                             input logic [31:0] ed, input logic estall, input logic erdy);
    vec_t t;
    t.r = r; t.av = av; t.ard = ard; t.ad = ad; t.lv = lv; t.lrd = lrd; t.ld = ld;
    t.iv = 1'b0; t.ird = '0;
    t.ewe = ewe; t.erd = erd; t.ed = ed; t.estall = estall; t.erdy = erdy; t.ebusy = '0;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, check outputs at the following negedge.
  task automatic apply(input vec_t t, input string tag);
    rst = t.r; alu_valid = t.av; alu_rd = t.ard; alu_data = t.ad;
    ll_valid = t.lv; ll_rd = t.lrd; ll_data = t.ld;
    issue_valid = t.iv; issue_rd = t.ird;
    #1;
    chk({tag, " ll_ready"}, 32'(ll_ready), 32'(t.erdy));
    @(posedge clk);
    @(negedge clk);
    chk({tag, " wb_we"}, 32'(wb_we), 32'(t.ewe));
    if (t.ewe) begin
      chk({tag, " wb_rd"}, 32'(wb_rd), 32'(t.erd));
      chk({tag, " wb_data"}, wb_data, t.ed);
    end
    chk({tag, " stall_req"}, 32'(stall_req), 32'(t.estall));
    chk({tag, " busy_mask"}, busy_mask, t.ebusy);
  endtask

  vec_t      tbl[$];
  vec_t      t;
  wb_entry_t q[$];
  wb_entry_t e;
  int        starve_m;
  logic      m_stall;
  logic [31:0] busy_m;

  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ll_valid = 1'b0; ll_rd = '0; ll_data = '0; issue_valid = 1'b0; issue_rd = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset wb_we", 32'(wb_we), 32'd0);
    chk("reset wb_rd", 32'(wb_rd), 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    chk("reset stall_req", 32'(stall_req), 32'd0);
    chk("reset ll_ready", 32'(ll_ready), 32'd1);
    chk("reset busy_mask", busy_mask, 32'd0);

    //               r av ard  ad            lv lrd ld       we rd  data          st rdy
    tbl.push_back(v(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,        1, 5, 32'hDEADBEEF, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,            1, 7, 32'h11,   1, 7, 32'h11,       0, 1));
    tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,            0, 1));
    tbl.push_back(v(0, 1, 3, 32'h33,       1, 4, 32'h44,   1, 3, 32'h33,       0, 1));
    tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,        1, 4, 32'h44,       0, 1));
    tbl.push_back(v(0, 1, 1, 32'h1,        1, 10, 32'hA,   1, 1, 32'h1,        0, 1));
    tbl.push_back(v(0, 1, 2, 32'h2,        0, 0, 0,        1, 2, 32'h2,        0, 1));
    tbl.push_back(v(0, 1, 3, 32'h3,        0, 0, 0,        1, 3, 32'h3,        0, 1));
    tbl.push_back(v(0, 1, 4, 32'h4,        0, 0, 0,        1, 4, 32'h4,        0, 1));
    tbl.push_back(v(0, 1, 5, 32'h5,        0, 0, 0,        1, 5, 32'h5,        1, 1));
    tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,        1, 10, 32'hA,       0, 1));
    tbl.push_back(v(0, 1, 6, 32'h6,        1, 11, 32'hB,   1, 6, 32'h6,        0, 1));
    tbl.push_back(v(0, 1, 7, 32'h7,        1, 12, 32'hC,   1, 7, 32'h7,        1, 1));
    tbl.push_back(v(0, 0, 0, 0,            1, 13, 32'hD,   1, 11, 32'hB,       0, 0));
    tbl.push_back(v(0, 0, 0, 0,            1, 13, 32'hD,   1, 12, 32'hC,       0, 1));
    tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,        1, 13, 32'hD,       0, 1));
    tbl.push_back(v(0, 1, 0, 32'h99,       1, 0, 32'h77,   0, 0, 0,            0, 1));
    tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,            0, 1));
    tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,            0, 1));
    tbl.push_back(v(0, 1, 1, 32'h1,        1, 20, 32'h20,  1, 1, 32'h1,        0, 1));
    tbl.push_back(v(0, 1, 2, 32'h2,        1, 21, 32'h21,  1, 2, 32'h2,        1, 1));
    tbl.push_back(v(1, 0, 0, 0,            0, 0, 0,        0, 0, 0,            0, 0));
    tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,            0, 1));
    tbl.push_back(v(0, 0, 0, 0,            0, 0, 0,        0, 0, 0,            0, 1));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef SCOREBOARD_EN
    t = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    t.iv = 1'b1; t.ird = 5'd9; t.ebusy = 32'h200;
    apply(t, "sb_issue");
    t = v(0, 0, 0, 0, 1, 9, 32'h99, 1, 9, 32'h99, 0, 1);
    apply(t, "sb_retire");
    t = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    t.iv = 1'b1; t.ird = 5'd9; t.ebusy = 32'h200;
    apply(t, "sb_reissue");
    t = v(0, 0, 0, 0, 1, 9, 32'h98, 1, 9, 32'h98, 0, 1);
    t.iv = 1'b1; t.ird = 5'd9; t.ebusy = 32'h200;
    apply(t, "sb_set_wins");
`endif

    // Random traffic: model holds the queue as a plain list of accepted results.
    q.delete(); starve_m = 0; m_stall = 1'b0; busy_m = '0;
    for (int i = 0; i < 3000; i++) begin
      logic nonempty, alu_win, popped, byp;
      logic [31:0] clr, set;
      t.r   = (i == 0) || ($urandom_range(99) == 0);
      t.av  = m_stall ? 1'b0 : 1'($urandom_range(1));
      t.ard = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      t.ad  = $urandom;
      t.lv  = 1'($urandom_range(1));
      t.lrd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      t.ld  = $urandom;
      t.iv  = 1'($urandom_range(1));
      t.ird = 5'($urandom_range(31));
      t.erdy = (q.size() < LL_DEPTH);
      t.ewe = 1'b0; t.erd = '0; t.ed = '0;
      if (t.r) begin
        q.delete(); starve_m = 0; m_stall = 1'b0; busy_m = '0;
      end else begin
        nonempty = (q.size() != 0);
        alu_win = 1'b0; popped = 1'b0; byp = 1'b0; e = '0;
        if (t.av) begin
          alu_win = 1'b1; e.rd = t.ard; e.data = t.ad;
        end else if (nonempty) begin
          popped = 1'b1; e = q.pop_front();
        end else if (t.lv) begin
          byp = 1'b1; e.rd = t.lrd; e.data = t.ld;
        end
        if (t.lv && t.erdy && !byp) begin
          wb_entry_t n;
          n.rd = t.lrd; n.data = t.ld;
          q.push_back(n);
        end
        if (nonempty && alu_win) starve_m = (starve_m < STARVE_LIMIT) ? starve_m + 1 : starve_m;
        else                     starve_m = 0;
        m_stall = (starve_m == STARVE_LIMIT) || (q.size() == LL_DEPTH);
        t.ewe = (alu_win || popped || byp) && (e.rd != 0);
        t.erd = e.rd; t.ed = e.data;
        clr = (popped || byp) ? (32'd1 << e.rd) : 32'd0;
        set = (t.iv && t.ird != 0) ? (32'd1 << t.ird) : 32'd0;
        busy_m = (busy_m & ~clr) | set;
      end
      t.estall = m_stall;
`ifdef SCOREBOARD_EN
      t.ebusy = busy_m;
`else
      t.ebusy = '0;
`endif
      apply(t, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
